// File: rtl/fir_ctrl_pkg.sv
// Shared types and defaults for the FIR coefficient sequencer.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DEF_NTAPS     = 7;
  localparam int DEF_W         = 8;
  localparam int DEF_FLUSH_CYC = 7;

  // Extracts tap `tap` from a default-sized packed coefficient bus.
  function automatic logic [DEF_W-1:0] coef_slice(
    input logic [DEF_NTAPS*DEF_W-1:0] bus,
    input int unsigned                tap
  );
    return bus[tap*DEF_W +: DEF_W];
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow coefficient registers plus the atomic copy into the active bus.
module fir_coef_bank
  import fir_ctrl_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int W     = DEF_W,
  parameter int IW    = $clog2(NTAPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_idx,
  input  logic [W-1:0]         wr_data,
  input  logic                 commit,
  output logic [NTAPS*W-1:0]   coef_o
);

  logic [W-1:0]       shadow_q [NTAPS];
  logic [W-1:0]       shadow_d [NTAPS];
  logic [NTAPS*W-1:0] coef_q;
  logic [NTAPS*W-1:0] coef_d;

  // The commit sees the byte written on the same edge, so the last tap
  // lands in the active bus together with the six already held in shadow.
  always_comb begin
    coef_d = coef_q;
    for (int i = 0; i < NTAPS; i++) begin
      shadow_d[i] = (wr_en && (wr_idx == IW'(i))) ? wr_data : shadow_q[i];
      if (commit) begin
        coef_d[i*W +: W] = shadow_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        shadow_q[i] <= '0;
      end
      coef_q <= '0;
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      coef_q <= coef_d;
    end
  end

  assign coef_o = coef_q;

endmodule

// File: rtl/fir_coef_sequencer.sv
// Loads FIR taps over a byte handshake, commits them atomically, then
// zero-flushes the FIR delay line before real samples resume.
module fir_coef_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int NTAPS     = DEF_NTAPS,
  parameter int W         = DEF_W,
  parameter int FLUSH_CYC = DEF_FLUSH_CYC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic [W-1:0]         cfg_data,
  output logic                 cfg_ready,
  input  logic                 sample_valid,
  input  logic [W-1:0]         sample_in,
  output logic [W-1:0]         data_o,
  output logic                 data_valid_o,
  output logic [NTAPS*W-1:0]   coef_o,
  output logic                 busy,
  output logic                 load_done,
  output logic                 err
);

  localparam int IW = $clog2(NTAPS + 1);
  localparam int CW = $clog2(FLUSH_CYC + 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic [W-1:0]  data_q, data_d;
  logic          dvld_q, dvld_d;
  logic          busy_q, busy_d;
  logic          load_done_q, load_done_d;
  logic          err_q, err_d;

  logic          xfer;
  logic          wr_en;
  logic          commit;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cfg_ready_d = cfg_ready_q;
    load_done_d = 1'b0;
    err_d       = 1'b0;
    wr_en       = 1'b0;
    commit      = 1'b0;
    xfer        = cfg_valid && cfg_ready_q;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d     = LOAD;
          idx_d       = '0;
          cfg_ready_d = 1'b1;
        end
      end
      LOAD: begin
        // A restart outranks a byte offered in the same cycle.
        if (cfg_start) begin
          idx_d = '0;
        end else if (xfer) begin
          wr_en = 1'b1;
          if (idx_q == IW'(NTAPS - 1)) begin
            commit      = 1'b1;
            idx_d       = '0;
            cnt_d       = CW'(FLUSH_CYC);
            state_d     = FLUSH;
            cfg_ready_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        err_d = cfg_start;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          cnt_d       = '0;
          state_d     = IDLE;
          load_done_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cfg_ready_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);

    // Gate on the next state so the zero window starts right after commit.
    if (state_d == FLUSH) begin
      data_d = '0;
      dvld_d = 1'b0;
    end else begin
      data_d = sample_valid ? sample_in : '0;
      dvld_d = sample_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      cfg_ready_q <= 1'b0;
      data_q      <= '0;
      dvld_q      <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cfg_ready_q <= cfg_ready_d;
      data_q      <= data_d;
      dvld_q      <= dvld_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
    end
  end

  fir_coef_bank #(
    .NTAPS (NTAPS),
    .W     (W),
    .IW    (IW)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (cfg_data),
    .commit  (commit),
    .coef_o  (coef_o)
  );

  assign cfg_ready    = cfg_ready_q;
  assign data_o       = data_q;
  assign data_valid_o = dvld_q;
  assign busy         = busy_q;
  assign load_done    = load_done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Scoreboard bench for fir_coef_sequencer: directed loads, restart, illegal start, reset mid-flush.
module tb_fir_coef_sequencer;
  import fir_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start, cfg_valid, cfg_ready;
  logic [7:0]  cfg_data;
  logic        sample_valid;
  logic [7:0]  sample_in;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic [55:0] coef_o;
  logic        busy, load_done, err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  exp_data_q [$];
  logic [55:0] exp_coef_q [$];
  bit          exp_err_q  [$];

  fir_coef_sequencer #(.NTAPS(7), .W(8), .FLUSH_CYC(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .coef_o       (coef_o),
    .busy         (busy),
    .load_done    (load_done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (data_valid_o) begin
        if (exp_data_q.size() == 0) chk("sample_unexpected", 64'(data_o), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("sample_data", 64'(data_o), 64'(exp_data_q.pop_front()));
      end
      if (load_done) begin
        if (exp_coef_q.size() == 0) chk("load_done_unexpected", 64'(coef_o), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("load_done_coef", 64'(coef_o), 64'(exp_coef_q.pop_front()));
      end
      if (err) begin
        if (exp_err_q.size() == 0) chk("err_unexpected", 64'd1, 64'd0);
        else chk("err_pulse", 64'(err), 64'(exp_err_q.pop_front()));
      end
    end
  end

  task automatic start_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("load_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("load_busy", 64'(busy), 64'd1);
  endtask

  // Sends base..base+6; ends one cycle after the commit edge (flush cycle 1).
  task automatic load7(input logic [7:0] base, input bit gaps,
                       input logic [55:0] old_coef, input logic [55:0] new_coef,
                       input bit expect_done);
    for (int i = 0; i < 7; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = base + 8'(i);
      if (i == 6) begin
        chk("coef_not_early", 64'(coef_o), 64'(old_coef));
        if (expect_done) exp_coef_q.push_back(new_coef);
      end
      tick();
      cfg_valid = 1'b0;
      if (gaps && i < 6) begin
        cfg_data = 8'h55;
        tick();
      end
    end
    chk("coef_commit_edge", 64'(coef_o), 64'(new_coef));
    chk("cfg_ready_after_commit", 64'(cfg_ready), 64'd0);
  endtask

  // Walks the flush window; drives dropped samples in cycles 1..6 and an
  // optional illegal cfg_start at cycle err_at.
  task automatic flush_run(input string tag, input int err_at);
    int zeros;
    int done_cyc;
    zeros    = 0;
    done_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      if (load_done) begin
        done_cyc = c;
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        break;
      end
      if (busy && !data_valid_o && data_o == 8'h00) zeros++;
      sample_valid = (c <= 6);
      sample_in    = 8'hEE;
      cfg_start    = (c == err_at);
      if (c == err_at) exp_err_q.push_back(1'b1);
      tick();
      cfg_start    = 1'b0;
    end
    sample_valid = 1'b0;
    chk({tag, "_zero_cycles"}, 64'(zeros), 64'd7);
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'd8);
    tick();
    chk({tag, "_done_one_pulse"}, 64'(load_done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld_cnt;
    int busy_cnt;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    sample_valid = 1'b0; sample_in = 8'h00;
    #2;
    chk("rst_coef", 64'(coef_o), 64'd0);
    chk("rst_ctrl", 64'({data_o, data_valid_o, cfg_ready, busy, load_done, err}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: idle sample pass-through, cfg_valid ignored
    sample_valid = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h33;
    sample_in = 8'h05; exp_data_q.push_back(8'h05); tick();
    chk("idle_cfg_ready", 64'(cfg_ready), 64'd0);
    sample_in = 8'h05; exp_data_q.push_back(8'h05); tick();
    sample_in = 8'h81; exp_data_q.push_back(8'h81); tick();
    chk("idle_cfg_ready2", 64'(cfg_ready), 64'd0);
    sample_valid = 1'b0; cfg_valid = 1'b0;
    tick();
    chk("idle_gate_off", 64'({data_o, data_valid_o}), 64'd0);
    chk("idle_coef", 64'(coef_o), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // 2: full back-to-back load
    start_load();
    load7(8'h01, 1'b0, 56'h0, 56'h07060504030201, 1'b1);
    chk("tap6_slice", 64'(coef_slice(coef_o, 6)), 64'h07);
    flush_run("full", 0);

    // 3: backpressured load
    start_load();
    load7(8'hA0, 1'b1, 56'h07060504030201, 56'hA6A5A4A3A2A1A0, 1'b1);
    flush_run("bp", 0);

    // 4: restart with a dropped byte on the restart cycle
    start_load();
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_data = 8'h09; tick();
    end
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h09;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    chk("restart_coef_kept", 64'(coef_o), 64'hA6A5A4A3A2A1A0);
    load7(8'h01, 1'b0, 56'hA6A5A4A3A2A1A0, 56'h07060504030201, 1'b1);
    flush_run("restart", 0);

    // 5: illegal start during flush cycle 3
    start_load();
    load7(8'h11, 1'b0, 56'h07060504030201, 56'h17161514131211, 1'b1);
    flush_run("illegal", 3);
    chk("illegal_coef", 64'(coef_o), 64'h17161514131211);

    // 6: asynchronous reset at flush cycle 2
    start_load();
    load7(8'h21, 1'b0, 56'h17161514131211, 56'h27262524232221, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_coef", 64'(coef_o), 64'd0);
    chk("midrst_ctrl", 64'({data_o, data_valid_o, cfg_ready, busy, load_done, err}), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    ld_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (load_done) ld_cnt++;
      if (busy) busy_cnt++;
      tick();
    end
    chk("midrst_no_load_done", 64'(ld_cnt), 64'd0);
    chk("midrst_idle", 64'(busy_cnt), 64'd0);
    chk("midrst_coef_after", 64'(coef_o), 64'd0);

    chk("sample_q_drained", 64'(exp_data_q.size()), 64'd0);
    chk("coef_q_drained", 64'(exp_coef_q.size()), 64'd0);
    chk("err_q_drained", 64'(exp_err_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_coef_sequencer.md
Name: fir_coef_sequencer

Overview:
- Configuration and sequencing controller for the 7-tap FIR/root datapath.
- Accepts a byte stream of new tap coefficients over a valid/ready handshake into shadow registers, then commits them atomically to the active coefficient bus.
- After each commit, forces zero samples into the FIR for a fixed number of cycles so the delay line holds no old-coefficient history.
- Sits between the board-level data/coefficient inputs and the FIR instance; replaces static coefficient wiring and the simple enable gating of the sample input.

Parameters:
- NTAPS, 7, number of FIR taps/coefficients.
- W, 8, width of each coefficient and of each sample.
- FLUSH_CYC, 7, number of forced-zero sample cycles after a commit (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  request to begin a new coefficient load.
- cfg_valid  in  1  cfg_data is valid.
- cfg_data  in  W  next coefficient, tap 0 first.
- cfg_ready  out  1  sequencer accepts cfg_data this cycle.
- sample_valid  in  1  sample_in is valid; gating enable.
- sample_in  in  W  raw input sample.
- data_o  out  W  sample driven to the FIR Data_i input.
- data_valid_o  out  1  data_o carries a real sample, not a zero or flush sample.
- coef_o  out  NTAPS*W  active coefficients; tap i occupies bits [i*W +: W], wired to B0..B6.
- busy  out  1  state is not IDLE.
- load_done  out  1  one-cycle pulse when the flush completes.
- err  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (asynchronous): state=IDLE, idx=0, flush counter=0, shadow=0, coef_o=0, data_o=0, data_valid_o=0, cfg_ready=0, busy=0, load_done=0, err=0.
- IDLE:
  - cfg_ready=0; cfg_valid is ignored.
  - cfg_start=1 → LOAD, idx=0.
- LOAD:
  - cfg_ready=1 (registered; it is 1 in the first LOAD cycle).
  - Transfer occurs when cfg_valid && cfg_ready: shadow[idx] ← cfg_data, idx++.
  - On the transfer with idx==NTAPS-1, on that same edge: coef_o ← {cfg_data, shadow[NTAPS-2:0]}, flush counter ← FLUSH_CYC, state → FLUSH, cfg_ready → 0.
  - cfg_start=1 in LOAD restarts the load: idx ← 0 and partial shadow contents are discarded. coef_o is unchanged and err is not raised. If cfg_start and a transfer occur in the same cycle, cfg_start wins and the byte is dropped.
  - coef_o never changes during LOAD.
- FLUSH:
  - data_o=0 and data_valid_o=0 for exactly FLUSH_CYC consecutive cycles, beginning with the cycle after the commit edge.
  - The counter decrements once per cycle. When it reaches 0: state → IDLE and load_done=1 for one cycle (the first IDLE cycle).
  - cfg_start in FLUSH is ignored and pulses err for one cycle.
- Sample path (registered, 1-cycle latency):
  - Outside FLUSH: data_o ← sample_valid ? sample_in : 0, and data_valid_o ← sample_valid.
  - Samples presented while in FLUSH are dropped, not queued.
- busy=1 in LOAD and FLUSH.
- Arithmetic: idx and the flush counter are sized by $clog2 of (NTAPS+1) and (FLUSH_CYC+1). No wrap is possible because idx is cleared on commit.
- Reset mid-LOAD or mid-FLUSH returns every output to its reset value, including coef_o=0.

Decomposition:
- Package fir_ctrl_pkg:
  - state enum {IDLE, LOAD, FLUSH};
  - default NTAPS/W/FLUSH_CYC constants;
  - coefficient-slice helper function.
- One sub-module, fir_coef_bank: shadow register array plus the atomic commit into the active bank (inputs wr_en, wr_idx, wr_data, commit; output coef_o).
- FSM, counters and sample gating live in the top of the block.

Test Plan:
1. Reset then idle: sample_valid=1, sample_in=8'h05 each cycle → data_o=8'h05 one cycle later; coef_o=0; cfg_ready=0, even with cfg_valid=1.
2. Full load: cfg_start, then bytes 1,2,3,4,5,6,7 back-to-back → coef_o=0x07060504030201 on the 7th accept edge, not earlier. data_o=0 and data_valid_o=0 for exactly 7 cycles. load_done pulses once. busy is high from LOAD entry to the pulse.
3. Backpressured load: cfg_valid toggling 1/0 between bytes 8'hA0..8'hA6 → coef_o=0xA6A5A4A3A2A1A0. Bytes offered while cfg_valid=0 are not written.
4. Restart: cfg_start, bytes 9,9,9, cfg_start, then bytes 1..7 → coef_o=0x07060504030201, no err.
5. Illegal start: cfg_start during FLUSH cycle 3 → err pulses one cycle, FLUSH still lasts 7 cycles, coef_o unchanged.
6. Reset mid-FLUSH: rst_n low asynchronously at flush cycle 2 → coef_o=0, state IDLE, load_done never pulses.
